// File: rtl/hsv_pkg.sv
// Shared constants and the output packing helper for the HSV-to-RGB pipeline.
`timescale 1ns/1ps
package hsv_pkg;

  localparam int ORDER_RGB = 0;
  localparam int ORDER_GRB = 1;
  localparam int ORDER_BRG = 2;

  localparam logic [2:0] REG_0 = 3'd0;
  localparam logic [2:0] REG_1 = 3'd1;
  localparam logic [2:0] REG_2 = 3'd2;
  localparam logic [2:0] REG_3 = 3'd3;
  localparam logic [2:0] REG_4 = 3'd4;
  localparam logic [2:0] REG_5 = 3'd5;

  localparam int PACK_MAX_W = 12;

  // Components are zero-extended to the widest supported width; caller keeps the low 3*w bits.
  function automatic logic [3*PACK_MAX_W-1:0] pack_rgb(input int order,
                                                       input logic [PACK_MAX_W-1:0] r,
                                                       input logic [PACK_MAX_W-1:0] g,
                                                       input logic [PACK_MAX_W-1:0] b,
                                                       input int w);
    logic [3*PACK_MAX_W-1:0] hi, mid, lo;
    case (order)
      ORDER_GRB: begin hi = 36'(g); mid = 36'(r); lo = 36'(b); end
      ORDER_BRG: begin hi = 36'(b); mid = 36'(r); lo = 36'(g); end
      default:   begin hi = 36'(r); mid = 36'(g); lo = 36'(b); end
    endcase
    return (hi << (2 * w)) | (mid << w) | lo;
  endfunction

endpackage

// File: rtl/hsv_pipe_ctrl.sv
// Global-stall flow control: valid and frame-marker shift chains for the pipeline.
`timescale 1ns/1ps
module hsv_pipe_ctrl #(
  parameter int STAGES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_last,
  input  logic out_ready,
  output logic en,
  output logic in_ready,
  output logic out_valid,
  output logic out_last
);

  logic [STAGES:1] vld_q, vld_d;
  logic [STAGES:1] last_q, last_d;

  assign en        = !vld_q[STAGES] | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[STAGES];
  assign out_last  = last_q[STAGES];

  // Bubbles shift through with the data; nothing is compacted.
  always_comb begin
    vld_d  = vld_q;
    last_d = last_q;
    if (en) begin
      vld_d  = {vld_q[STAGES-1:1], in_valid};
      last_d = {last_q[STAGES-1:1], in_valid & in_last};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/hsv_to_rgb_pipe.sv
// Four-stage HSV to RGB converter with brightness scaling, gray bypass and colour-order packing.
`timescale 1ns/1ps
module hsv_to_rgb_pipe
  import hsv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int HUE_W  = 8,
  parameter int ORDER  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [HUE_W-1:0]      in_h,
  input  logic [DATA_W-1:0]     in_s,
  input  logic [DATA_W-1:0]     in_v,
  input  logic                  in_last,
  input  logic [DATA_W-1:0]     bright,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3*DATA_W-1:0]   out_rgb,
  output logic                  out_last
);

  localparam int DW2 = 2 * DATA_W;
  localparam logic [DATA_W-1:0] MAX = '1;

  function automatic logic [DATA_W-1:0] mul_hi(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DW2-1:0] m;
    m = DW2'(a) * DW2'(b);
    return DATA_W'(m >> DATA_W);
  endfunction

  // bright+1 needs one extra bit so that bright=MAX is an exact identity.
  function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] c,
                                              input logic [DATA_W-1:0] b);
    logic [DW2:0] m;
    m = (DW2 + 1)'(c) * ((DW2 + 1)'(b) + (DW2 + 1)'(1));
    return DATA_W'(m >> DATA_W);
  endfunction

  logic en;

  hsv_pipe_ctrl #(.STAGES(4)) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_last  (in_last),
    .out_ready(out_ready),
    .en       (en),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_last (out_last)
  );

  logic [HUE_W+2:0]  h6;
  logic [HUE_W-1:0]  frac_raw;
  logic [DATA_W-1:0] frac_d;

  assign h6       = (HUE_W + 3)'(in_h) * (HUE_W + 3)'(6);
  assign frac_raw = HUE_W'(h6);

  generate
    if (HUE_W >= DATA_W) begin : g_frac_dn
      assign frac_d = DATA_W'(frac_raw >> (HUE_W - DATA_W));
    end else begin : g_frac_up
      assign frac_d = DATA_W'(frac_raw) << (DATA_W - HUE_W);
    end
  endgenerate

  logic [2:0]          reg1_q, reg1_d, reg2_q, reg2_d;
  logic [DATA_W-1:0]   frac1_q, frac1_d, sat1_q, sat1_d, val1_q, val1_d, bri1_q, bri1_d;
  logic                gray1_q, gray1_d, gray2_q, gray2_d;
  logic [DATA_W-1:0]   p2_q, p2_d, q2_q, q2_d, t2_q, t2_d, val2_q, val2_d, bri2_q, bri2_d;
  logic [DATA_W-1:0]   r3_q, r3_d, g3_q, g3_d, b3_q, b3_d, bri3_q, bri3_d;
  logic [3*DATA_W-1:0] rgb_q, rgb_d;

  always_comb begin
    // stage 1: hue sector and fraction
    reg1_d  = 3'(h6 >> HUE_W);
    frac1_d = frac_d;
    sat1_d  = in_s;
    val1_d  = in_v;
    bri1_d  = bright;
    gray1_d = (in_s == '0);
    // stage 2: p/q/t terms
    p2_d    = mul_hi(val1_q, MAX - sat1_q);
    q2_d    = mul_hi(val1_q, MAX - mul_hi(sat1_q, frac1_q));
    t2_d    = mul_hi(val1_q, MAX - mul_hi(sat1_q, MAX - frac1_q));
    val2_d  = val1_q;
    reg2_d  = reg1_q;
    gray2_d = gray1_q;
    bri2_d  = bri1_q;
    // stage 3: sector select, with the zero-saturation case forced exact
    case (reg2_q)
      REG_0:   begin r3_d = val2_q; g3_d = t2_q;   b3_d = p2_q;   end
      REG_1:   begin r3_d = q2_q;   g3_d = val2_q; b3_d = p2_q;   end
      REG_2:   begin r3_d = p2_q;   g3_d = val2_q; b3_d = t2_q;   end
      REG_3:   begin r3_d = p2_q;   g3_d = q2_q;   b3_d = val2_q; end
      REG_4:   begin r3_d = t2_q;   g3_d = p2_q;   b3_d = val2_q; end
      default: begin r3_d = val2_q; g3_d = p2_q;   b3_d = q2_q;   end
    endcase
    if (gray2_q) begin
      r3_d = val2_q;
      g3_d = val2_q;
      b3_d = val2_q;
    end
    bri3_d = bri2_q;
    // stage 4: brightness and packing
    rgb_d = (3 * DATA_W)'(pack_rgb(ORDER,
                                   PACK_MAX_W'(scale(r3_q, bri3_q)),
                                   PACK_MAX_W'(scale(g3_q, bri3_q)),
                                   PACK_MAX_W'(scale(b3_q, bri3_q)),
                                   DATA_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg1_q <= '0; frac1_q <= '0; sat1_q <= '0; val1_q <= '0; bri1_q <= '0; gray1_q <= 1'b0;
      p2_q   <= '0; q2_q    <= '0; t2_q   <= '0; val2_q <= '0; reg2_q <= '0;
      gray2_q <= 1'b0; bri2_q <= '0;
      r3_q   <= '0; g3_q    <= '0; b3_q   <= '0; bri3_q <= '0;
      rgb_q  <= '0;
    end else if (en) begin
      reg1_q <= reg1_d; frac1_q <= frac1_d; sat1_q <= sat1_d; val1_q <= val1_d;
      bri1_q <= bri1_d; gray1_q <= gray1_d;
      p2_q   <= p2_d; q2_q <= q2_d; t2_q <= t2_d; val2_q <= val2_d; reg2_q <= reg2_d;
      gray2_q <= gray2_d; bri2_q <= bri2_d;
      r3_q   <= r3_d; g3_q <= g3_d; b3_q <= b3_d; bri3_q <= bri3_d;
      rgb_q  <= rgb_d;
    end
  end

  assign out_rgb = rgb_q;

endmodule

// File: tb/tb_hsv_to_rgb_pipe.sv
// Scoreboard bench: GRB and RGB instances driven in parallel, checked on every hand-off.
`timescale 1ns/1ps
module tb_hsv_to_rgb_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_h, in_s, in_v, bright;
  logic        in_last;
  logic        out_ready;
  logic        in_ready, in_ready0;
  logic        out_valid, out_valid0;
  logic [23:0] out_rgb, out_rgb0;
  logic        out_last, out_last0;

  always #5 clk = ~clk;

  hsv_to_rgb_pipe #(.DATA_W(8), .HUE_W(8), .ORDER(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_h(in_h), .in_s(in_s), .in_v(in_v), .in_last(in_last), .bright(bright),
    .out_valid(out_valid), .out_ready(out_ready), .out_rgb(out_rgb), .out_last(out_last)
  );

  hsv_to_rgb_pipe #(.DATA_W(8), .HUE_W(8), .ORDER(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_h(in_h), .in_s(in_s), .in_v(in_v), .in_last(in_last), .bright(bright),
    .out_valid(out_valid0), .out_ready(out_ready), .out_rgb(out_rgb0), .out_last(out_last0)
  );

  typedef struct {
    logic [23:0] rgb1;
    logic [23:0] rgb0;
    logic        last;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_chk = 0;
  int   n_pass = 0;
  int   ecyc = 0;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_rgb = '0;
  logic        prev_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor: hand-off checks, stall checks, then acceptance capture, then en-cycle count.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", {8'h0, out_rgb}, 32'hDEAD);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rgb_grb", {8'h0, out_rgb}, {8'h0, e.rgb1});
          chk("rgb_rgb", {8'h0, out_rgb0}, {8'h0, e.rgb0});
          chk("last", {31'h0, out_last}, {31'h0, e.last});
          chk("latency", ecyc - e.acc, 4);
        end
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", {31'h0, in_ready}, 0);
        if (prev_stall) begin
          chk("stall_hold_rgb", {8'h0, out_rgb}, {8'h0, prev_rgb});
          chk("stall_hold_last", {31'h0, out_last}, {31'h0, prev_last});
        end
        prev_stall = 1'b1;
        prev_rgb   = out_rgb;
        prev_last  = out_last;
      end else begin
        prev_stall = 1'b0;
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e = cur;
        e.acc = ecyc;
        sb.push_back(e);
      end
      if (in_ready) ecyc++;
    end
  end

  // Called at posedge+1; holds the pixel until accepted, returns at posedge+1 after acceptance.
  task automatic send(input logic [7:0] h, s, v, b, input logic l,
                      input logic [23:0] e1, e0);
    int w;
    in_h = h; in_s = s; in_v = v; bright = b; in_last = l; in_valid = 1'b1;
    cur.rgb1 = e1; cur.rgb0 = e0; cur.last = l; cur.acc = 0;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++w > 100) begin
        chk("accept_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 60) begin
      @(posedge clk); #1;
      w++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_h = '0; in_s = '0; in_v = '0; bright = '0;
    in_last = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_out_rgb", {8'h0, out_rgb}, 0);
    chk("rst_out_last", {31'h0, out_last}, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'h0, in_ready}, 1);

    // directed vectors, back-to-back
    send(8'd0,   8'd255, 8'd255, 8'd255, 1'b1, 24'h00FF00, 24'hFF0000);
    send(8'd128, 8'd255, 8'd255, 8'd255, 1'b0, 24'hFE00FF, 24'h00FEFF);
    send(8'd77,  8'd0,   8'd100, 8'd255, 1'b1, 24'h646464, 24'h646464);
    send(8'd200, 8'd180, 8'd0,   8'd255, 1'b0, 24'h000000, 24'h000000);
    send(8'd0,   8'd255, 8'd255, 8'd127, 1'b0, 24'h007F00, 24'h7F0000);
    send(8'd0,   8'd255, 8'd255, 8'd0,   1'b1, 24'h000000, 24'h000000);
    send(8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 24'h00FF05, 24'hFF0005);
    send(8'd43,  8'd255, 8'd255, 8'd255, 1'b1, 24'hFFFD00, 24'hFDFF00);
    drain();

    // 8-pixel stream with a 5-cycle downstream stall in the middle
    fork
      for (int i = 0; i < 8; i++) begin
        logic [7:0] v;
        v = 8'(10 * i + 5);
        send(8'(30 * i), 8'd0, v, 8'd255, i == 7, {v, v, v}, {v, v, v});
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // reset with pixels in flight
    send(8'd10, 8'd0, 8'h11, 8'd255, 1'b0, 24'h111111, 24'h111111);
    send(8'd20, 8'd0, 8'h22, 8'd255, 1'b0, 24'h222222, 24'h222222);
    send(8'd30, 8'd0, 8'h33, 8'd255, 1'b1, 24'h333333, 24'h333333);
    @(posedge clk); #1;
    chk("pre_rst_valid", {31'h0, out_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, out_valid}, 0);
    chk("mid_rst_rgb", {8'h0, out_rgb}, 0);
    chk("mid_rst_last", {31'h0, out_last}, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_idle", {31'h0, out_valid}, 0);
    send(8'd40, 8'd0, 8'h44, 8'd255, 1'b1, 24'h444444, 24'h444444);
    drain();
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
